// File: rtl/jk_bank_sequencer.sv
// Command sequencer for an external JK flip-flop bank: clear/set/load/toggle and multi-step up/down counting.
// Optional saturating count mode is enabled by defining JK_CNT_SATURATE_EN.
module jk_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_LOAD   = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_CNT_UP = 3'd5;
  localparam logic [2:0] OP_CNT_DN = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] data_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             sat_reg, sat_next;
  logic             sat_hit;
  logic [WIDTH-1:0] up_mask, dn_mask;

  // Synchronous-counter toggle enables: a bit flips when all lower bits are 1 (up) or 0 (down).
  assign up_mask[0] = 1'b1;
  assign dn_mask[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_carry
      assign up_mask[gi] = up_mask[gi-1] & q_in[gi-1];
      assign dn_mask[gi] = dn_mask[gi-1] & ~q_in[gi-1];
    end
  endgenerate

`ifdef JK_CNT_SATURATE_EN
  assign sat_hit = ((op_reg == OP_CNT_UP) && (&q_in)) ||
                   ((op_reg == OP_CNT_DN) && (~|q_in));
`else
  assign sat_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sat_next   = sat_reg;
    j_out      = '0;
    k_out      = '0;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cnt_next = cmd_cnt;
          sat_next = 1'b0;
          if (((cmd_op == OP_CNT_UP) || (cmd_op == OP_CNT_DN)) && (cmd_cnt == '0))
            state_next = DONE;
          else
            state_next = EXEC;
        end
      end
      EXEC: begin
        busy       = 1'b1;
        state_next = DONE;
        case (op_reg)
          OP_CLEAR:  k_out = '1;
          OP_SET:    j_out = '1;
          OP_LOAD: begin
            j_out = data_reg;
            k_out = ~data_reg;
          end
          OP_TOGGLE: begin
            j_out = data_reg;
            k_out = data_reg;
          end
          OP_CNT_UP, OP_CNT_DN: begin
            if (sat_hit) begin
              sat_next = 1'b1;
            end else begin
              j_out    = (op_reg == OP_CNT_UP) ? up_mask : dn_mask;
              k_out    = j_out;
              cnt_next = cnt_reg - 1'b1;
              if (cnt_reg != {{(CNT_W-1){1'b0}}, 1'b1})
                state_next = EXEC;
            end
          end
          default: ;
        endcase
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        err        = (op_reg == OP_RSVD) | sat_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      sat_reg   <= 1'b0;
      op_reg    <= OP_NOP;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sat_reg   <= sat_next;
      if (state_reg == IDLE && cmd_valid) begin
        op_reg   <= cmd_op;
        data_reg <= cmd_data;
      end
    end
  end

endmodule
